// File: rtl/df_tile_sequencer_if.sv
// Tile descriptor channel between the sequencer and the DMA/array side.
// The sequencer presents one descriptor per transfer; the consumer accepts it with i_tile_ready.
interface df_tile_sequencer_if #(
   parameter int ADRW = 32
);

   logic            o_tile_valid;
   logic            i_tile_ready;
   logic [ADRW-1:0] o_psums_addr;
   logic [ADRW-1:0] o_ifmaps_addr;
   logic [ADRW-1:0] o_weights_addr;
   logic [11:0]     o_x_idx;
   logic [11:0]     o_y_idx;
   logic [11:0]     o_k_idx;
   logic [11:0]     o_c_idx;
   logic            o_first_c;
   logic            o_last_c;

   modport master (
      output o_tile_valid,
      input  i_tile_ready,
      output o_psums_addr,
      output o_ifmaps_addr,
      output o_weights_addr,
      output o_x_idx,
      output o_y_idx,
      output o_k_idx,
      output o_c_idx,
      output o_first_c,
      output o_last_c
   );

   modport slave (
      input  o_tile_valid,
      output i_tile_ready,
      input  o_psums_addr,
      input  o_ifmaps_addr,
      input  o_weights_addr,
      input  o_x_idx,
      input  o_y_idx,
      input  o_k_idx,
      input  o_c_idx,
      input  o_first_c,
      input  o_last_c
   );

endinterface

// File: rtl/df_tile_sequencer.sv
// Dataflow tile sequencer: walks a four-deep tile loop nest (k outer, then y, then x,
// with c innermost) and emits one tile descriptor (indices plus psums/ifmaps/weights
// addresses) per accepted transfer. Addresses are built incrementally from per-level
// base registers, so no multipliers are needed.
module df_tile_sequencer #(
   parameter int ADRW = 32
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_start,
   input  logic            i_abort,
   input  logic [11:0]     i_x_lim,
   input  logic [11:0]     i_y_lim,
   input  logic [11:0]     i_k_lim,
   input  logic [11:0]     i_c_lim,
   input  logic [11:0]     i_psums_x_step,
   input  logic [23:0]     i_psums_y_step,
   input  logic [23:0]     i_psums_k_step,
   input  logic [11:0]     i_ifmaps_x_step,
   input  logic [23:0]     i_ifmaps_y_step,
   input  logic [23:0]     i_ifmaps_c_step,
   input  logic [11:0]     i_weights_k_step,
   input  logic [23:0]     i_weights_c_step,
   input  logic [ADRW-1:0] i_psums_base,
   input  logic [ADRW-1:0] i_ifmaps_base,
   input  logic [ADRW-1:0] i_weights_base,
   df_tile_sequencer_if.master tile,
   output logic            o_busy,
   output logic            o_done
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t state;

   // Configuration captured at start so the sweep is immune to input changes.
   logic [11:0]     x_lim_q;
   logic [11:0]     y_lim_q;
   logic [11:0]     k_lim_q;
   logic [11:0]     c_lim_q;
   logic [ADRW-1:0] px_step;
   logic [ADRW-1:0] py_step;
   logic [ADRW-1:0] pk_step;
   logic [ADRW-1:0] ix_step;
   logic [ADRW-1:0] iy_step;
   logic [ADRW-1:0] ic_step;
   logic [ADRW-1:0] wk_step;
   logic [ADRW-1:0] wc_step;
   logic [ADRW-1:0] ifmaps_base_q;

   // Loop indices.
   logic [11:0]     x_idx;
   logic [11:0]     y_idx;
   logic [11:0]     k_idx;
   logic [11:0]     c_idx;

   // Per-level address bases: each holds the address with all inner indices at zero.
   logic [ADRW-1:0] p_k_base;
   logic [ADRW-1:0] p_y_base;
   logic [ADRW-1:0] i_y_base;
   logic [ADRW-1:0] i_xy_base;
   logic [ADRW-1:0] w_k_base;

   // Registered descriptor outputs.
   logic            tile_valid;
   logic [ADRW-1:0] psums_addr;
   logic [ADRW-1:0] ifmaps_addr;
   logic [ADRW-1:0] weights_addr;
   logic            first_c;
   logic            last_c;
   logic            busy;
   logic            done;

   logic            c_wrap;
   logic            x_wrap;
   logic            y_wrap;
   logic            k_wrap;
   logic            last_tile;

   assign c_wrap    = (c_idx == c_lim_q);
   assign x_wrap    = (x_idx == x_lim_q);
   assign y_wrap    = (y_idx == y_lim_q);
   assign k_wrap    = (k_idx == k_lim_q);
   assign last_tile = c_wrap && x_wrap && y_wrap && k_wrap;

   assign tile.o_tile_valid   = tile_valid;
   assign tile.o_psums_addr   = psums_addr;
   assign tile.o_ifmaps_addr  = ifmaps_addr;
   assign tile.o_weights_addr = weights_addr;
   assign tile.o_x_idx        = x_idx;
   assign tile.o_y_idx        = y_idx;
   assign tile.o_k_idx        = k_idx;
   assign tile.o_c_idx        = c_idx;
   assign tile.o_first_c      = first_c;
   assign tile.o_last_c       = last_c;
   assign o_busy              = busy;
   assign o_done              = done;

   // Sequencer FSM: captures configuration, advances the loop nest on each transfer
   // and updates the incremental address registers alongside the indices.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state         <= IDLE;
         x_lim_q       <= '0;
         y_lim_q       <= '0;
         k_lim_q       <= '0;
         c_lim_q       <= '0;
         px_step       <= '0;
         py_step       <= '0;
         pk_step       <= '0;
         ix_step       <= '0;
         iy_step       <= '0;
         ic_step       <= '0;
         wk_step       <= '0;
         wc_step       <= '0;
         ifmaps_base_q <= '0;
         x_idx         <= '0;
         y_idx         <= '0;
         k_idx         <= '0;
         c_idx         <= '0;
         p_k_base      <= '0;
         p_y_base      <= '0;
         i_y_base      <= '0;
         i_xy_base     <= '0;
         w_k_base      <= '0;
         tile_valid    <= 1'b0;
         psums_addr    <= '0;
         ifmaps_addr   <= '0;
         weights_addr  <= '0;
         first_c       <= 1'b0;
         last_c        <= 1'b0;
         busy          <= 1'b0;
         done          <= 1'b0;
      end else if (i_abort) begin
         state      <= IDLE;
         tile_valid <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (i_start) begin
                  x_lim_q       <= i_x_lim;
                  y_lim_q       <= i_y_lim;
                  k_lim_q       <= i_k_lim;
                  c_lim_q       <= i_c_lim;
                  px_step       <= ADRW'(i_psums_x_step);
                  py_step       <= ADRW'(i_psums_y_step);
                  pk_step       <= ADRW'(i_psums_k_step);
                  ix_step       <= ADRW'(i_ifmaps_x_step);
                  iy_step       <= ADRW'(i_ifmaps_y_step);
                  ic_step       <= ADRW'(i_ifmaps_c_step);
                  wk_step       <= ADRW'(i_weights_k_step);
                  wc_step       <= ADRW'(i_weights_c_step);
                  ifmaps_base_q <= i_ifmaps_base;
                  x_idx         <= '0;
                  y_idx         <= '0;
                  k_idx         <= '0;
                  c_idx         <= '0;
                  p_k_base      <= i_psums_base;
                  p_y_base      <= i_psums_base;
                  psums_addr    <= i_psums_base;
                  i_y_base      <= i_ifmaps_base;
                  i_xy_base     <= i_ifmaps_base;
                  ifmaps_addr   <= i_ifmaps_base;
                  w_k_base      <= i_weights_base;
                  weights_addr  <= i_weights_base;
                  first_c       <= 1'b1;
                  last_c        <= (i_c_lim == 12'd0);
                  tile_valid    <= 1'b1;
                  busy          <= 1'b1;
                  state         <= ISSUE;
               end
            end
            ISSUE: begin
               if (tile.i_tile_ready) begin
                  if (last_tile) begin
                     tile_valid <= 1'b0;
                     done       <= 1'b1;
                     state      <= DONE;
                  end else if (!c_wrap) begin
                     c_idx        <= c_idx + 12'd1;
                     ifmaps_addr  <= ifmaps_addr + ic_step;
                     weights_addr <= weights_addr + wc_step;
                     first_c      <= 1'b0;
                     last_c       <= (c_idx + 12'd1 == c_lim_q);
                  end else begin
                     c_idx        <= '0;
                     first_c      <= 1'b1;
                     last_c       <= (c_lim_q == 12'd0);
                     weights_addr <= w_k_base;
                     if (!x_wrap) begin
                        x_idx       <= x_idx + 12'd1;
                        psums_addr  <= psums_addr + px_step;
                        i_xy_base   <= i_xy_base + ix_step;
                        ifmaps_addr <= i_xy_base + ix_step;
                     end else begin
                        x_idx <= '0;
                        if (!y_wrap) begin
                           y_idx       <= y_idx + 12'd1;
                           p_y_base    <= p_y_base + py_step;
                           psums_addr  <= p_y_base + py_step;
                           i_y_base    <= i_y_base + iy_step;
                           i_xy_base   <= i_y_base + iy_step;
                           ifmaps_addr <= i_y_base + iy_step;
                        end else begin
                           y_idx        <= '0;
                           k_idx        <= k_idx + 12'd1;
                           p_k_base     <= p_k_base + pk_step;
                           p_y_base     <= p_k_base + pk_step;
                           psums_addr   <= p_k_base + pk_step;
                           i_y_base     <= ifmaps_base_q;
                           i_xy_base    <= ifmaps_base_q;
                           ifmaps_addr  <= ifmaps_base_q;
                           w_k_base     <= w_k_base + wk_step;
                           weights_addr <= w_k_base + wk_step;
                        end
                     end
                  end
               end
            end
            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               tile_valid <= 1'b0;
               busy       <= 1'b0;
               done       <= 1'b0;
               state      <= IDLE;
            end
         endcase
      end
   end

endmodule
